bitmask_unpacker: RTL and testbench

BITMASK_UNPACKER -- requirements
Module: bitmask_unpacker

---
 rtl/bitmask_pkg.sv | 13 +
 rtl/lowest_set_bit.sv | 27 ++
 rtl/bitmask_unpacker.sv | 90 +++++++++
 tb/tb_bitmask_unpacker.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bitmask_pkg.sv
// Shared constants and FSM encoding for the bitmask unpacker.
package bitmask_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t EMIT = 2'd1;
  localparam state_t ZERO = 2'd2;

endpackage

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index and one-hot of the lowest set bit, plus a
// flag that is high when exactly one bit of the vector is set.
module lowest_set_bit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic             single_o
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = vec_i & (~vec_i + WIDTH'(1));

  // Only one bit set means the vector equals its own lowest-bit isolate.
  assign single_o = (vec_i != '0) && (onehot_o == vec_i);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx_o = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/bitmask_unpacker.sv
// Decomposes an accepted mask into a stream of set-bit indices, lowest first.
// An all-zero mask yields one beat flagged empty. Outputs are decoded from the
// state register and the pending-bit register only.
module bitmask_unpacker import bitmask_pkg::*; #(
  parameter int unsigned WIDTH = bitmask_pkg::WIDTH,
  parameter int unsigned IDX_W = bitmask_pkg::IDX_W  // must equal clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             out_empty
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;

  logic [IDX_W-1:0] low_idx;
  logic [WIDTH-1:0] low_onehot;
  logic             low_single;

  lowest_set_bit #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_lowest_set_bit (
    .vec_i    (pend_q),
    .idx_o    (low_idx),
    .onehot_o (low_onehot),
    .single_o (low_single)
  );

  // Output decode: EMIT reports the lowest pending bit, ZERO a fixed empty beat.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == EMIT) || (state_q == ZERO);
    out_index = (state_q == EMIT) ? low_idx : '0;
    out_last  = ((state_q == EMIT) && low_single) || (state_q == ZERO);
    out_empty = (state_q == ZERO);
  end

  // Next-state: clear overrides any handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (clear) begin
      state_d = IDLE;
      pend_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pend_d  = mask;
            state_d = (mask != '0) ? EMIT : ZERO;
          end
        end
        EMIT: begin
          if (out_ready) begin
            pend_d = pend_q & ~low_onehot;
            if (low_single) state_d = IDLE;
          end
        end
        ZERO: begin
          if (out_ready) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          pend_d  = '0;
        end
      endcase
    end
  end

  // State and pending-bit registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_bitmask_unpacker.sv
// Self-checking bench: directed scenarios plus random masks against a queue model.
module tb_bitmask_unpacker;

  localparam int unsigned W  = 32;
  localparam int unsigned IW = 5;

  logic          clock = 1'b0;
  logic          resetn;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  mask;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          out_empty;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bitmask_unpacker #(
    .WIDTH (W),
    .IDX_W (IW)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Offer a mask at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [W-1:0] m);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    mask     = m;
    @(negedge clock);
    in_valid = 1'b0;
    mask     = $urandom;
  endtask

  // Expected beats are the ascending set-bit positions; a zero mask gives one empty beat.
  task automatic run_mask(input logic [W-1:0] m, input int prob, input int stall);
    int exp_q[$];
    int cyc = 0;
    bit emp;
    for (int b = 0; b < int'(W); b++) if (m[b]) exp_q.push_back(b);
    emp = (exp_q.size() == 0);
    if (emp) exp_q.push_back(0);
    send(m);
    while (exp_q.size() > 0 && cyc < 400) begin
      check("out_valid", {31'd0, out_valid}, 32'd1);
      check("out_index", {27'd0, out_index}, exp_q[0]);
      check("out_last", {31'd0, out_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
      check("out_empty", {31'd0, out_empty}, emp ? 32'd1 : 32'd0);
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      out_ready = (cyc >= stall) && ($urandom_range(99) < prob);
      if (out_ready) void'(exp_q.pop_front());
      @(negedge clock);
      cyc++;
    end
    check("beats_remaining", exp_q.size(), 32'd0);
    out_ready = 1'($urandom_range(1));
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_index"}, {27'd0, out_index}, 32'd0);
    check({tag, "_last"}, {31'd0, out_last}, 32'd0);
    check({tag, "_empty"}, {31'd0, out_empty}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] rm;
    resetn    = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mask      = '0;
    #1;
    check_reset_outputs("reset");
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Sparse mask with top bit, no backpressure.
    run_mask(32'h8000_0011, 100, 0);
    // Empty mask.
    run_mask(32'h0000_0000, 100, 0);
    // Held backpressure: index 1 must stay put for 3 cycles.
    run_mask(32'h0000_0006, 100, 3);
    // All ones.
    run_mask(32'hFFFF_FFFF, 100, 0);
    // Back-to-back with only the top bit.
    run_mask(32'h8000_0000, 100, 0);

    // Clear during second beat of 0x0F.
    send(32'h0000_000F);
    check("clr_beat0", {27'd0, out_index}, 32'd0);
    out_ready = 1'b1;
    @(negedge clock);
    check("clr_beat1", {27'd0, out_index}, 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("clr_valid", {31'd0, out_valid}, 32'd0);
      check("clr_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clock);
    end

    // Clear wins over a simultaneous input handshake.
    in_valid = 1'b1;
    mask     = 32'h0000_0003;
    clear    = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    clear    = 1'b0;
    check("clr_in_valid", {31'd0, out_valid}, 32'd0);
    check("clr_in_ready2", {31'd0, in_ready}, 32'd1);

    // Reset pulsed mid-emission of 0xF0.
    send(32'h0000_00F0);
    check("rst_beat0", {27'd0, out_index}, 32'd4);
    out_ready = 1'b1;
    @(negedge clock);
    check("rst_beat1", {27'd0, out_index}, 32'd5);
    #1 resetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clock);
    end
    run_mask(32'h0000_00F0, 100, 0);

    // Random masks and random backpressure.
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(3))
        0:       rm = $urandom & $urandom & $urandom;
        1:       rm = 32'(1) << $urandom_range(31);
        2:       rm = (t % 5 == 0) ? '0 : $urandom;
        default: rm = $urandom;
      endcase
      run_mask(rm, 40 + int'($urandom_range(60)), int'($urandom_range(2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
